// File: rtl/dlpe_bank_ctrl_if.sv
// Write/initialisation request port between a register-interface master and the
// DLPE latch-bank write sequencer.
interface dlpe_bank_ctrl_if #(
   parameter int unsigned AW = 3,
   parameter int unsigned DW = 8
);
   logic          WR_REQ;
   logic [AW-1:0] WR_ADDR;
   logic [DW-1:0] WR_DATA;
   logic          INIT_REQ;
   logic          WR_ACK;
   logic          WR_ERR;
   logic          BUSY;

   modport master (
      output WR_REQ, WR_ADDR, WR_DATA, INIT_REQ,
      input  WR_ACK, WR_ERR, BUSY
   );

   modport slave (
      input  WR_REQ, WR_ADDR, WR_DATA, INIT_REQ,
      output WR_ACK, WR_ERR, BUSY
   );
endinterface

// File: rtl/dlpe_bank_ctrl.sv
// Write sequencer for a bank of DLPE latch words: orders data/enable setup, gate
// pulse and hold, and drives the bank-wide PRESET on reset or on request.
module dlpe_bank_ctrl #(
   parameter int unsigned NWORDS    = 8,
   parameter int unsigned AW        = 3,
   parameter int unsigned DW        = 8,
   parameter int unsigned SETUP_CYC = 1,
   parameter int unsigned GATE_CYC  = 2,
   parameter int unsigned HOLD_CYC  = 1,
   parameter int unsigned PRST_CYC  = 2
) (
   input  logic              CLK,
   input  logic              CLEAR,
   dlpe_bank_ctrl_if.slave   wr,
   output logic              L_PRESET,
   output logic              L_G,
   output logic [NWORDS-1:0] L_CE,
   output logic [DW-1:0]     L_D
);
   localparam int unsigned MAX_SG = (SETUP_CYC > GATE_CYC) ? SETUP_CYC : GATE_CYC;
   localparam int unsigned MAX_HP = (HOLD_CYC > PRST_CYC) ? HOLD_CYC : PRST_CYC;
   localparam int unsigned MAX_C  = (MAX_SG > MAX_HP) ? MAX_SG : MAX_HP;
   localparam int unsigned CW     = $clog2(MAX_C + 1);

   localparam logic [2:0] ST_INIT  = 3'd0;
   localparam logic [2:0] ST_IDLE  = 3'd1;
   localparam logic [2:0] ST_SETUP = 3'd2;
   localparam logic [2:0] ST_OPEN  = 3'd3;
   localparam logic [2:0] ST_HOLD  = 3'd4;

   logic [2:0]        state, state_n;
   logic [CW-1:0]     cnt, cnt_n;
   logic              preset_n, g_n, ack_q, ack_n, err_q, err_n, busy_q, busy_n;
   logic [NWORDS-1:0] ce_n;
   logic [DW-1:0]     d_n;
   logic              last, addr_bad;

   assign last     = (cnt == CW'(1));
   assign addr_bad = ({1'b0, wr.WR_ADDR} >= (AW+1)'(NWORDS));

   assign wr.WR_ACK = ack_q;
   assign wr.WR_ERR = err_q;
   assign wr.BUSY   = busy_q;

   // Reset lands in INIT so the bank is preset for PRST_CYC edges after release.
   always_ff @(posedge CLK or posedge CLEAR) begin
      if (CLEAR) begin
         state    <= ST_INIT;
         cnt      <= CW'(PRST_CYC);
         L_PRESET <= 1'b1;
         L_G      <= 1'b0;
         L_CE     <= '0;
         L_D      <= '0;
         ack_q    <= 1'b0;
         err_q    <= 1'b0;
         busy_q   <= 1'b1;
      end else begin
         state    <= state_n;
         cnt      <= cnt_n;
         L_PRESET <= preset_n;
         L_G      <= g_n;
         L_CE     <= ce_n;
         L_D      <= d_n;
         ack_q    <= ack_n;
         err_q    <= err_n;
         busy_q   <= busy_n;
      end
   end

   // Next state and next registered outputs; latch controls hold unless changed.
   always_comb begin
      state_n  = state;
      cnt_n    = cnt;
      preset_n = L_PRESET;
      g_n      = L_G;
      ce_n     = L_CE;
      d_n      = L_D;
      busy_n   = busy_q;
      ack_n    = 1'b0;
      err_n    = 1'b0;

      case (state)
         ST_INIT: begin
            if (last) begin
               state_n  = ST_IDLE;
               preset_n = 1'b0;
               busy_n   = 1'b0;
            end else begin
               cnt_n = cnt - CW'(1);
            end
         end
         ST_IDLE: begin
            // A request seen during the ack cycle is the one just completed.
            if (wr.INIT_REQ) begin
               state_n  = ST_INIT;
               cnt_n    = CW'(PRST_CYC);
               preset_n = 1'b1;
               busy_n   = 1'b1;
            end else if (!ack_q && wr.WR_REQ) begin
               if (addr_bad) begin
                  ack_n = 1'b1;
                  err_n = 1'b1;
               end else begin
                  state_n = ST_SETUP;
                  cnt_n   = CW'(SETUP_CYC);
                  ce_n    = NWORDS'(1) << wr.WR_ADDR;
                  d_n     = wr.WR_DATA;
                  busy_n  = 1'b1;
               end
            end
         end
         ST_SETUP: begin
            if (last) begin
               state_n = ST_OPEN;
               cnt_n   = CW'(GATE_CYC);
               g_n     = 1'b1;
            end else begin
               cnt_n = cnt - CW'(1);
            end
         end
         ST_OPEN: begin
            if (last) begin
               state_n = ST_HOLD;
               cnt_n   = CW'(HOLD_CYC);
               g_n     = 1'b0;
            end else begin
               cnt_n = cnt - CW'(1);
            end
         end
         ST_HOLD: begin
            if (last) begin
               state_n = ST_IDLE;
               ce_n    = '0;
               ack_n   = 1'b1;
               busy_n  = 1'b0;
            end else begin
               cnt_n = cnt - CW'(1);
            end
         end
         default: begin
            state_n  = ST_INIT;
            cnt_n    = CW'(PRST_CYC);
            preset_n = 1'b1;
            g_n      = 1'b0;
            ce_n     = '0;
            busy_n   = 1'b1;
         end
      endcase
   end
endmodule

// File: tb/tb_dlpe_bank_ctrl.sv
// Self-checking bench for dlpe_bank_ctrl: directed scenarios plus random traffic
// against a timeline-schedule model and a behavioural latch-bank model.
module tb_dlpe_bank_ctrl;
   localparam int unsigned NW = 6;
   localparam int unsigned AW = 3;
   localparam int unsigned DW = 8;
   localparam int unsigned S  = 1;
   localparam int unsigned G  = 2;
   localparam int unsigned H  = 1;
   localparam int unsigned P  = 2;

   logic          clk = 1'b0;
   logic          clear;
   logic          L_PRESET, L_G;
   logic [NW-1:0] L_CE;
   logic [DW-1:0] L_D;

   dlpe_bank_ctrl_if #(.AW(AW), .DW(DW)) ifc ();

   dlpe_bank_ctrl #(
      .NWORDS(NW), .AW(AW), .DW(DW),
      .SETUP_CYC(S), .GATE_CYC(G), .HOLD_CYC(H), .PRST_CYC(P)
   ) dut (
      .CLK(clk), .CLEAR(clear), .wr(ifc.slave),
      .L_PRESET(L_PRESET), .L_G(L_G), .L_CE(L_CE), .L_D(L_D)
   );

   always #5 clk = ~clk;

   // One expected output frame per clock; wa is the word a completing write targets.
   typedef struct packed {
      logic          preset;
      logic          g;
      logic [NW-1:0] ce;
      logic [DW-1:0] d;
      logic          ack;
      logic          err;
      logic          busy;
      logic [AW-1:0] wa;
   } frame_t;

   frame_t        cur;
   frame_t        q[$];
   logic [DW-1:0] gold [NW];
   logic [DW-1:0] bank [NW];
   int            n_vec = 0;
   int            n_err = 0;

   // Behavioural DLPE bank: PRESET forces ones, gate+enable makes a word transparent.
   always @(L_PRESET or L_G or L_CE or L_D) begin
      for (int i = 0; i < int'(NW); i++) begin
         if (L_PRESET)             bank[i] = 8'hFF;
         else if (L_G && L_CE[i]) bank[i] = L_D;
      end
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [NW*DW-1:0] pack(input logic [DW-1:0] arr [NW]);
      logic [NW*DW-1:0] v;
      v = '0;
      for (int i = 0; i < int'(NW); i++) v[i*DW +: DW] = arr[i];
      return v;
   endfunction

   function automatic logic [NW+DW+4:0] exp_outs(input frame_t f);
      return {f.preset, f.g, f.ce, f.d, f.ack, f.err, f.busy};
   endfunction

   // Preset schedule: PRESET/BUSY for P cycles, then idle; the bank reads all ones.
   task automatic sched_init();
      frame_t f;
      f        = cur;
      f.preset = 1'b1;
      f.busy   = 1'b1;
      f.g      = 1'b0;
      f.ce     = '0;
      f.ack    = 1'b0;
      f.err    = 1'b0;
      cur      = f;
      q.delete();
      for (int k = 1; k < int'(P); k++) q.push_back(f);
      f.preset = 1'b0;
      f.busy   = 1'b0;
      q.push_back(f);
      for (int i = 0; i < int'(NW); i++) gold[i] = 8'hFF;
   endtask

   task automatic model_reset();
      cur = '0;
      sched_init();
   endtask

   // Advance the model by one clock edge given the inputs sampled at that edge.
   task automatic model_step(input logic i, input logic r, input logic [AW-1:0] a,
                             input logic [DW-1:0] d);
      frame_t f;
      logic   was_ack;
      if (q.size() != 0) begin
         cur = q.pop_front();
         if (cur.ack && !cur.err) gold[cur.wa] = cur.d;
      end else begin
         was_ack = cur.ack;
         cur.ack = 1'b0;
         cur.err = 1'b0;
         if (i) begin
            sched_init();
         end else if (!was_ack && r) begin
            if (int'(a) >= int'(NW)) begin
               cur.ack = 1'b1;
               cur.err = 1'b1;
            end else begin
               f      = cur;
               f.ce   = '0;
               f.ce[a] = 1'b1;
               f.d    = d;
               f.busy = 1'b1;
               f.wa   = a;
               for (int k = 1; k <= int'(S + G + H); k++) begin
                  f.g = (k > int'(S)) && (k <= int'(S + G));
                  if (k == 1) cur = f;
                  else        q.push_back(f);
               end
               f.g    = 1'b0;
               f.ce   = '0;
               f.busy = 1'b0;
               f.ack  = 1'b1;
               q.push_back(f);
            end
         end
      end
   endtask

   task automatic check_all();
      chk("outs", 64'({L_PRESET, L_G, L_CE, L_D, ifc.WR_ACK, ifc.WR_ERR, ifc.BUSY}),
          64'(exp_outs(cur)));
      if (q.size() == 0) chk("bank", 64'(pack(bank)), 64'(pack(gold)));
   endtask

   task automatic cycle(input logic c, input logic i, input logic r,
                        input logic [AW-1:0] a, input logic [DW-1:0] d);
      @(negedge clk);
      clear        = c;
      ifc.INIT_REQ = i;
      ifc.WR_REQ   = r;
      ifc.WR_ADDR  = a;
      ifc.WR_DATA  = d;
      if (c) begin
         #1;
         model_reset();
         check_all();
      end
      @(posedge clk);
      if (c) model_reset();
      else   model_step(i, r, a, d);
      #1;
      check_all();
   endtask

   // Hold a request until the DUT acks (bounded); n is the cycle count to ack, 0 if none.
   task automatic write_txn(input logic [AW-1:0] a, input logic [DW-1:0] d,
                            input bit drop, output int n);
      n = 0;
      for (int k = 1; k <= 30; k++) begin
         cycle(1'b0, 1'b0, 1'b1, a, d);
         if (ifc.WR_ACK === 1'b1) begin
            n = k;
            break;
         end
      end
      if (drop) cycle(1'b0, 1'b0, 1'b0, a, d);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      int            n;
      logic          rq;
      logic [AW-1:0] ra;
      logic [DW-1:0] rd;

      clear        = 1'b1;
      ifc.INIT_REQ = 1'b0;
      ifc.WR_REQ   = 1'b0;
      ifc.WR_ADDR  = '0;
      ifc.WR_DATA  = '0;
      model_reset();

      repeat (3) cycle(1'b1, 1'b0, 1'b0, 3'd0, 8'h00);
      repeat (3) cycle(1'b0, 1'b0, 1'b0, 3'd0, 8'h00);
      chk("rst_busy", 64'(ifc.BUSY), 64'(0));
      chk("rst_preset", 64'(L_PRESET), 64'(0));

      write_txn(3'd5, 8'hA5, 1'b1, n);
      chk("wr_lat", 64'(n), 64'(S + G + H + 1));
      chk("word5", 64'(bank[5]), 64'(8'hA5));
      chk("word0", 64'(bank[0]), 64'(8'hFF));

      write_txn(3'd2, 8'h11, 1'b0, n);
      write_txn(3'd4, 8'h22, 1'b1, n);
      chk("b2b_period", 64'(n), 64'(S + G + H + 2));
      chk("word2", 64'(bank[2]), 64'(8'h11));
      chk("word4", 64'(bank[4]), 64'(8'h22));

      write_txn(3'd6, 8'h5A, 1'b0, n);
      chk("err_lat", 64'(n), 64'(1));
      chk("err_flag", 64'(ifc.WR_ERR), 64'(1));
      chk("err_ld", 64'(L_D), 64'(8'h22));
      cycle(1'b0, 1'b0, 1'b0, 3'd6, 8'h5A);

      cycle(1'b0, 1'b1, 1'b1, 3'd1, 8'h3C);
      chk("init_preset", 64'(L_PRESET), 64'(1));
      write_txn(3'd1, 8'h3C, 1'b1, n);
      chk("init_wr_lat", 64'(n), 64'(P + 1 + S + G + H));
      chk("word1", 64'(bank[1]), 64'(8'h3C));
      chk("word5_wiped", 64'(bank[5]), 64'(8'hFF));

      cycle(1'b0, 1'b0, 1'b1, 3'd3, 8'h77);
      cycle(1'b0, 1'b0, 1'b1, 3'd3, 8'h77);
      chk("open_g", 64'(L_G), 64'(1));
      cycle(1'b1, 1'b0, 1'b0, 3'd3, 8'h77);
      chk("abort_ce", 64'(L_CE), 64'(0));
      repeat (4) cycle(1'b0, 1'b0, 1'b0, 3'd3, 8'h77);
      chk("abort_word3", 64'(bank[3]), 64'(8'hFF));

      rq = 1'b0;
      ra = '0;
      rd = '0;
      for (int k = 0; k < 500; k++) begin
         if (cur.ack) begin
            if ($urandom_range(1) == 1) begin
               ra = AW'($urandom_range(7));
               rd = DW'($urandom);
            end else begin
               rq = 1'b0;
            end
         end else if (!rq && $urandom_range(3) == 0) begin
            rq = 1'b1;
            ra = AW'($urandom_range(7));
            rd = DW'($urandom);
         end
         cycle($urandom_range(99) == 0, $urandom_range(19) == 0, rq, ra, rd);
      end
      repeat (10) cycle(1'b0, 1'b0, 1'b0, ra, rd);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
